uart_sync_fifo: RTL and testbench

Parametrised single-clock FIFO for the UART TX and RX data paths. It replaces the fixed shift-register buffer with a circular buffer that has independent push and pop. It also provides exact occupancy, programmable almost-full and almost-empty flags, sticky overflow and underflow error flags, and a synchronous flush. One instance sits between the host register interface and the TX serialiser, and another between the RX deserialiser and the host.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_fifo_ctrl.sv | 102 ++++++++++
 rtl/uart_sync_fifo.sv | 78 +++++++
 tb/tb_uart_sync_fifo.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and width helpers for the FIFO slice.
package uart_pkg;

  localparam int unsigned UART_WORD_SIZE  = 8;
  localparam int unsigned UART_FIFO_DEPTH = 16;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // One extra bit so the counter can hold the full value FIFO_DEPTH.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_ctrl.sv
// FIFO bookkeeping: pointers, occupancy counter, registered flags and sticky errors.
module uart_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = UART_FIFO_DEPTH,
  parameter int unsigned AFULL_LVL  = FIFO_DEPTH - 2,
  parameter int unsigned AEMPTY_LVL = 2,
  localparam int unsigned PtrW = ptr_w(FIFO_DEPTH),
  localparam int unsigned CntW = cnt_w(FIFO_DEPTH)
) (
  input  logic            gclk,
  input  logic            rstn,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            err_clr_i,
  output logic            wr_en_o,
  output logic [PtrW-1:0] wr_addr_o,
  output logic [PtrW-1:0] rd_addr_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            almost_full_o,
  output logic            almost_empty_o,
  output logic            overflow_o,
  output logic            underflow_o
);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full_q, full_d, empty_q, empty_d;
  logic            afull_q, afull_d, aempty_q, aempty_d;
  logic            overflow_q, overflow_d, underflow_q, underflow_d;
  logic            push_w, pop_w, ov_set, un_set;

  always_comb begin
    push_w   = push_i & (~full_q | pop_i);
    pop_w    = pop_i & ~empty_q;
    ov_set   = push_i & full_q & ~pop_i;
    un_set   = pop_i & empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      push_w   = 1'b0;
      pop_w    = 1'b0;
      ov_set   = 1'b0;
      un_set   = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_w) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_w)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push_w && !pop_w)      count_d = count_q + CntW'(1);
      else if (pop_w && !push_w) count_d = count_q - CntW'(1);
    end
    // Setting an error wins over a simultaneous clear.
    overflow_d  = ov_set | (overflow_q & ~err_clr_i);
    underflow_d = un_set | (underflow_q & ~err_clr_i);
    full_d      = (count_d == CntW'(FIFO_DEPTH));
    empty_d     = (count_d == '0);
    afull_d     = (count_d >= CntW'(AFULL_LVL));
    aempty_d    = (count_d <= CntW'(AEMPTY_LVL));
  end

  always_ff @(posedge gclk) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign wr_en_o        = push_w & rstn;
  assign wr_addr_o      = wr_ptr_q;
  assign rd_addr_o      = rd_ptr_q;
  assign count_o        = count_q;
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO for the UART TX/RX data paths.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WORD_SIZE     = UART_WORD_SIZE,
  parameter int unsigned FIFO_DEPTH    = UART_FIFO_DEPTH,
  parameter int unsigned AFULL_LVL     = FIFO_DEPTH - 2,
  parameter int unsigned AEMPTY_LVL    = 2,
  parameter bit          FIFO_FLUSH_EN = 1'b1,
  localparam int unsigned PtrW = ptr_w(FIFO_DEPTH),
  localparam int unsigned CntW = cnt_w(FIFO_DEPTH)
) (
  input  logic                 gclk,
  input  logic                 rstn,
  input  logic                 flush_i,
  input  logic                 push_i,
  input  logic [WORD_SIZE-1:0] din_i,
  input  logic                 pop_i,
  input  logic                 err_clr_i,
  output logic [WORD_SIZE-1:0] dout_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 almost_full_o,
  output logic                 almost_empty_o,
  output logic [CntW-1:0]      count_o,
  output logic                 overflow_o,
  output logic                 underflow_o
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_sync_fifo: FIFO_DEPTH must be a power of two >= 2");
  end
  if (AFULL_LVL < 1 || AFULL_LVL > FIFO_DEPTH) begin : g_bad_afull
    $error("uart_sync_fifo: AFULL_LVL out of range");
  end
  if (AEMPTY_LVL > FIFO_DEPTH - 1) begin : g_bad_aempty
    $error("uart_sync_fifo: AEMPTY_LVL out of range");
  end

  logic                 wr_en;
  logic [PtrW-1:0]      wr_addr, rd_addr;
  logic [WORD_SIZE-1:0] mem_q [FIFO_DEPTH];

  uart_fifo_ctrl #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .AFULL_LVL  (AFULL_LVL),
    .AEMPTY_LVL (AEMPTY_LVL)
  ) u_ctrl (
    .gclk           (gclk),
    .rstn           (rstn),
    .flush_i        (flush_i),
    .push_i         (push_i),
    .pop_i          (pop_i),
    .err_clr_i      (err_clr_i),
    .wr_en_o        (wr_en),
    .wr_addr_o      (wr_addr),
    .rd_addr_o      (rd_addr),
    .count_o        (count_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  // wr_en is already suppressed during reset and flush.
  always_ff @(posedge gclk) begin
    if (FIFO_FLUSH_EN && (!rstn || flush_i)) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_addr] <= din_i;
    end
  end

  assign dout_o = empty_o ? '0 : mem_q[rd_addr];

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Directed self-checking bench for uart_sync_fifo (DEPTH 16, AFULL 14, AEMPTY 2).
module tb_uart_sync_fifo;

  logic       gclk = 1'b0;
  logic       rstn = 1'b0;
  logic       flush_i = 1'b0, push_i = 1'b0, pop_i = 1'b0, err_clr_i = 1'b0;
  logic [7:0] din_i = '0;
  logic [7:0] dout_o;
  logic       full_o, empty_o, almost_full_o, almost_empty_o, overflow_o, underflow_o;
  logic [4:0] count_o;

  int vectors = 0;
  int errors  = 0;

  uart_sync_fifo #(
    .WORD_SIZE     (8),
    .FIFO_DEPTH    (16),
    .AFULL_LVL     (14),
    .AEMPTY_LVL    (2),
    .FIFO_FLUSH_EN (1'b1)
  ) dut (
    .gclk           (gclk),
    .rstn           (rstn),
    .flush_i        (flush_i),
    .push_i         (push_i),
    .din_i          (din_i),
    .pop_i          (pop_i),
    .err_clr_i      (err_clr_i),
    .dout_o         (dout_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .count_o        (count_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic cyc(input logic psh, input logic [7:0] d, input logic pp,
                     input logic fl, input logic clr);
    push_i = psh; din_i = d; pop_i = pp; flush_i = fl; err_clr_i = clr;
    @(posedge gclk);
    #1;
    push_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0; err_clr_i = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " count"},  32'(count_o), 0);
    chk({tag, " empty"},  32'(empty_o), 1);
    chk({tag, " full"},   32'(full_o), 0);
    chk({tag, " aempty"}, 32'(almost_empty_o), 1);
    chk({tag, " afull"},  32'(almost_full_o), 0);
    chk({tag, " ovf"},    32'(overflow_o), 0);
    chk({tag, " unf"},    32'(underflow_o), 0);
    chk({tag, " dout"},   32'(dout_o), 0);
  endtask

  initial begin
    // Reset
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;
    chk_reset_state("reset");

    // Fill with 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      chk("fill count", 32'(count_o), i);
      chk("fill aempty", 32'(almost_empty_o), (i <= 2) ? 1 : 0);
      chk("fill afull", 32'(almost_full_o), (i >= 14) ? 1 : 0);
      chk("fill full", 32'(full_o), (i == 16) ? 1 : 0);
      chk("fill head", 32'(dout_o), 32'h01);
    end

    // Overflow: push while full, no pop
    cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    chk("ovf flag", 32'(overflow_o), 1);
    chk("ovf count", 32'(count_o), 16);
    chk("ovf head", 32'(dout_o), 32'h01);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf clear", 32'(overflow_o), 0);

    // Drain: 0x01..0x10 in order, 0x55 never seen
    for (int i = 1; i <= 16; i++) begin
      chk("drain data", 32'(dout_o), i);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("drain count", 32'(count_o), 16 - i);
    end
    chk("drain empty", 32'(empty_o), 1);
    chk("drain dout", 32'(dout_o), 0);
    chk("drain unf", 32'(underflow_o), 0);

    // Almost-full: asserts on 14th push, drops after one pop
    for (int i = 1; i <= 14; i++) begin
      cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
      chk("thr afull", 32'(almost_full_o), (i == 14) ? 1 : 0);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("thr afull pop", 32'(almost_full_o), 0);
    chk("thr count", 32'(count_o), 13);
    for (int i = 2; i <= 14; i++) begin
      chk("thr data", 32'(dout_o), 32'h40 + i);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("thr empty", 32'(empty_o), 1);

    // Wrap-around: push/pop 10, then push/pop 12 across the pointer wrap
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("wrap1 data", 32'(dout_o), 32'h20 + i);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 12; i++) cyc(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
    chk("wrap peak", 32'(count_o), 12);
    for (int i = 0; i < 12; i++) begin
      chk("wrap2 data", 32'(dout_o), 32'hA0 + i);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("wrap empty", 32'(empty_o), 1);

    // Empty with push and pop together
    cyc(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    chk("sim-empty unf", 32'(underflow_o), 1);
    chk("sim-empty count", 32'(count_o), 1);
    chk("sim-empty dout", 32'(dout_o), 32'h33);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("unf clear", 32'(underflow_o), 0);
    chk("unf drain empty", 32'(empty_o), 1);

    // Full with push and pop together
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    chk("sim-full pre", 32'(full_o), 1);
    cyc(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    chk("sim-full count", 32'(count_o), 16);
    chk("sim-full ovf", 32'(overflow_o), 0);
    chk("sim-full head", 32'(dout_o), 32'h81);
    for (int i = 1; i < 16; i++) begin
      chk("sim-full data", 32'(dout_o), 32'h80 + i);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("sim-full last", 32'(dout_o), 32'h77);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("sim-full empty", 32'(empty_o), 1);

    // Flush with push in the same cycle; sticky underflow survives flush
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("pre-flush unf", 32'(underflow_o), 1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    chk("pre-flush count", 32'(count_o), 5);
    cyc(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    chk("flush count", 32'(count_o), 0);
    chk("flush empty", 32'(empty_o), 1);
    chk("flush dout", 32'(dout_o), 0);
    chk("flush aempty", 32'(almost_empty_o), 1);
    chk("flush unf kept", 32'(underflow_o), 1);
    cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    chk("post-flush dout", 32'(dout_o), 32'h5A);
    chk("post-flush count", 32'(count_o), 1);

    // Reset mid-operation with push asserted
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0, 1'b0);
    chk("pre-reset count", 32'(count_o), 5);
    rstn = 1'b0;
    cyc(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;
    chk_reset_state("midreset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
